// File: rtl/bist_misr_compactor.sv
// bist_misr_compactor: 8-bit MISR response compactor with pattern count and golden-signature check
module bist_misr_compactor #(
  parameter int unsigned NPAT = 255,
  parameter logic [7:0] POLY = 8'h1D,
  parameter logic [7:0] SEED = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        z_valid,
  input  logic [7:0]  z_in,
  input  logic [7:0]  golden,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  signature,
  output logic [15:0] pat_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] LAST = 16'(NPAT - 1);
  state_t state, state_nx;
  logic load, cap, last;
  logic [7:0] sig_nx;
  always_comb begin
    load = start && (state != RUN);
    cap = (state == RUN) && z_valid;
    last = cap && (pat_count == LAST);
    sig_nx = {signature[6:0], 1'b0} ^ (signature[7] ? POLY : 8'h00) ^ z_in;
    state_nx = load ? RUN : last ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      signature <= SEED;
      pat_count <= 16'd0;
    end else begin
      state <= state_nx;
      busy <= state_nx == RUN;
      done <= state_nx == DONE;
      if (load) begin
        signature <= SEED;
        pat_count <= 16'd0;
        pass <= 1'b0;
      end else if (cap) begin
        signature <= sig_nx;
        pat_count <= pat_count + 16'd1;
        if (last) pass <= sig_nx == golden;
      end
    end
  end
endmodule

// File: tb/tb_bist_misr_compactor.sv
// tb_bist_misr_compactor: table-driven and scoreboard checks of the MISR compactor
module tb_bist_misr_compactor;
  logic clk = 0, rst = 1, start = 0, z_valid = 0;
  logic [7:0] z_in = 0, golden = 0;
  logic busy2, done2, pass2, busy4, done4, pass4, busyd, doned, passd;
  logic [7:0] sig2, sig4, sigd;
  logic [15:0] cnt2, cnt4, cntd;
  int total = 0, bad = 0;
  typedef struct {logic [7:0] sig; logic [15:0] cnt;} exp_t;
  exp_t q[$];
  typedef struct {logic s; logic v; logic [7:0] z; logic [7:0] sig; logic [15:0] cnt; logic busy; logic done;} vec_t;
  vec_t tbl[9];
  logic [7:0] gold_good, gold_bad;

  always #5 clk = ~clk;

  bist_misr_compactor #(.NPAT(2)) u2 (.clk(clk), .rst(rst), .start(start), .z_valid(z_valid), .z_in(z_in),
    .golden(golden), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_count(cnt2));
  bist_misr_compactor #(.NPAT(4)) u4 (.clk(clk), .rst(rst), .start(start), .z_valid(z_valid), .z_in(z_in),
    .golden(golden), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .pat_count(cnt4));
  bist_misr_compactor ud (.clk(clk), .rst(rst), .start(start), .z_valid(z_valid), .z_in(z_in),
    .golden(golden), .busy(busyd), .done(doned), .pass(passd), .signature(sigd), .pat_count(cntd));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] z);
    start = s; z_valid = v; z_in = z;
    @(posedge clk); #1;
    start = 0; z_valid = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step(1'b1, 1'b1, 8'hFF);
    rst = 0;
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s, input logic [7:0] z);
    logic [7:0] r;
    r = {s[6:0], 1'b0} ^ z;
    if (s[7]) r = r ^ 8'h1D;
    return r;
  endfunction

  // ripple adder; flt kills the carry entering bit 6
  function automatic logic [7:0] add(input logic [7:0] a, input logic [7:0] b, input logic flt);
    logic [7:0] s;
    logic c;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      if (flt && i == 5) c = 0;
    end
    return s;
  endfunction

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] sess_sig(input logic flt);
    logic [15:0] l;
    logic [7:0] s;
    l = 16'hACE1; s = 8'h00;
    for (int i = 0; i < 255; i++) begin
      s = mstep(s, add(l[7:0], l[15:8], flt));
      l = lfsr_nx(l);
    end
    return s;
  endfunction

  // full 255-pattern session on the default instance, checked through the scoreboard
  task automatic run_session(input logic flt, input logic exp_pass);
    logic [15:0] l;
    logic [7:0] s, z;
    l = 16'hACE1; s = 8'h00;
    step(1'b1, 1'b1, 8'h33);
    chk("sess_load", {sigd, cntd}, {8'h00, 16'd0});
    for (int i = 0; i < 255; i++) begin
      z = add(l[7:0], l[15:8], flt);
      l = lfsr_nx(l);
      step(1'b0, 1'b1, z);
      s = mstep(s, z);
      q.push_back('{sig: s, cnt: 16'(i + 1)});
    end
    @(negedge clk);
    chk("sess_done", {busyd, doned}, 2'b01);
    chk("sess_pass", passd, exp_pass);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_sig", sigd, e.sig);
      chk("sb_cnt", cntd, e.cnt);
    end
  end

  initial begin
    tbl[0] = '{1, 1, 8'hFF, 8'h00, 16'd0, 1, 0};
    tbl[1] = '{0, 1, 8'h01, 8'h01, 16'd1, 1, 0};
    tbl[2] = '{0, 0, 8'h77, 8'h01, 16'd1, 1, 0};
    tbl[3] = '{0, 1, 8'h02, 8'h00, 16'd2, 1, 0};
    tbl[4] = '{1, 0, 8'h00, 8'h00, 16'd2, 1, 0};
    tbl[5] = '{0, 1, 8'h03, 8'h03, 16'd3, 1, 0};
    tbl[6] = '{0, 0, 8'h00, 8'h03, 16'd3, 1, 0};
    tbl[7] = '{0, 1, 8'h04, 8'h02, 16'd4, 0, 1};
    tbl[8] = '{0, 1, 8'h55, 8'h02, 16'd4, 0, 1};
    gold_good = sess_sig(1'b0);
    gold_bad = sess_sig(1'b1);

    do_reset(2);
    chk("rst_sig", sigd, 8'h00);
    chk("rst_cnt", cntd, 16'd0);
    chk("rst_busy", busyd, 1'b0);
    chk("rst_done", doned, 1'b0);
    chk("rst_pass", passd, 1'b0);

    golden = 8'h57;
    step(1'b1, 1'b1, 8'h11);
    chk("s1_busy", busy2, 1'b1);
    chk("s1_sig0", sig2, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    chk("s1_sig1", sig2, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    chk("s1_sig2", sig2, 8'h57);
    chk("s1_done", {busy2, done2, pass2}, 3'b011);
    chk("s1_cnt", cnt2, 16'd2);
    golden = 8'h58;
    step(1'b1, 1'b0, 8'h00);
    chk("b2b_done", {busy2, done2, pass2}, 3'b100);
    chk("b2b_seed", {sig2, cnt2}, {8'h00, 16'd0});
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    chk("s2_sig", sig2, 8'h57);
    chk("s2_fail", {done2, pass2}, 2'b10);

    do_reset(1);
    golden = 8'h02;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].z);
      chk($sformatf("gap%0d_sig", i), sig4, tbl[i].sig);
      chk($sformatf("gap%0d_cnt", i), cnt4, tbl[i].cnt);
      chk($sformatf("gap%0d_bd", i), {busy4, done4}, {tbl[i].busy, tbl[i].done});
    end
    chk("gap_pass", pass4, 1'b1);

    do_reset(1);
    golden = gold_good;
    run_session(1'b0, 1'b1);
    run_session(1'b1, gold_bad == gold_good);
    chk("fault_differs", gold_bad != gold_good, 1'b1);
    run_session(1'b0, 1'b1);

    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i * 37 + 5));
    chk("abort_cnt", cntd, 16'd10);
    do_reset(1);
    chk("abort_idle", {busyd, doned, passd, sigd, cntd}, {3'b000, 8'h00, 16'd0});
    run_session(1'b0, 1'b1);
    chk("abort_sig", sigd, gold_good);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
